// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared encodings for the 16-bit ALU sequencer
// Purpose: op codes, ALU acode constants, FSM state type and the op->acode
//          helper used by alu_seq and alu_seq_mul.
// Ports:   none (package).
package alu_seq_pkg;

  // Sequencer operation codes (op input)
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  // External ALU operation codes (alu_acode output)
  localparam logic [2:0] AC_ADD = 3'b000;
  localparam logic [2:0] AC_ADC = 3'b001;
  localparam logic [2:0] AC_AND = 3'b100;
  localparam logic [2:0] AC_OR  = 3'b101;
  localparam logic [2:0] AC_XOR = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_MUL,
    S_DONE
  } state_t;

  // ALU code for the bytewise logic ops; same code on both bytes.
  function automatic logic [2:0] logic_acode(input logic [2:0] op);
    case (op)
      OP_AND:  return AC_AND;
      OP_OR:   return AC_OR;
      default: return AC_XOR;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - product register and iteration counter for MUL8
// Purpose: holds the shift-add partial product P and counts 8 iterations.
// Ports:   clk, rst (sync active-high); load seeds P={8'h00,a_lo};
//          step advances P with the ALU byte sum; p is the current partial
//          product, p_next its value after this step, last marks iteration 8.
module alu_seq_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [7:0]  a_lo,
  input  logic [7:0]  alu_r,
  input  logic        alu_carry_out,
  output logic [15:0] p,
  output logic [15:0] p_next,
  output logic        last
);

  logic [2:0] cnt;

  // The ALU carry becomes the new MSB; the consumed multiplier bit shifts out.
  assign p_next = {alu_carry_out, alu_r, p[7:1]};
  assign last   = (cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      p   <= 16'h0000;
      cnt <= 3'd0;
    end else if (load) begin
      p   <= {8'h00, a_lo};
      cnt <= 3'd0;
    end else if (step) begin
      p   <= p_next;
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle sequencer driving an external 8-bit ALU
// Purpose: runs 16-bit ADD/SUB/AND/OR/XOR as two byte steps on the ALU, and
//          optionally an 8x8 shift-add multiply (macro ALU_SEQ_MUL_EN).
// Ports:   clk, rst (sync active-high); start/op/a/b request;
//          alu_a/alu_b/alu_carry_in/alu_is_shift/alu_scode/alu_acode drive
//          the ALU, alu_r/alu_zero/alu_carry_out come back from it;
//          busy/done handshake; result/zero/carry/illegal held results.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_carry_in,
  output logic        alu_is_shift,
  output logic [1:0]  alu_scode,
  output logic [2:0]  alu_acode,
  input  logic [7:0]  alu_r,
  input  logic        alu_zero,
  input  logic        alu_carry_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        zero,
  output logic        carry,
  output logic        illegal
);

  state_t      state;
  logic [2:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [7:0]  r_lo;
  logic        z_lo;
  logic        c_lo;
  logic        legal;
  logic        step_carry;

`ifdef ALU_SEQ_MUL_EN
  logic [15:0] mul_p;
  logic [15:0] mul_p_next;
  logic        mul_last;

  alu_seq_mul u_mul (
    .clk           (clk),
    .rst           (rst),
    .load          (state == S_IDLE && start && op == OP_MUL),
    .step          (state == S_MUL),
    .a_lo          (a[7:0]),
    .alu_r         (alu_r),
    .alu_carry_out (alu_carry_out),
    .p             (mul_p),
    .p_next        (mul_p_next),
    .last          (mul_last)
  );

  assign legal = (op <= OP_XOR) || (op == OP_MUL);
`else
  assign legal = (op <= OP_XOR);
`endif

  assign alu_is_shift = 1'b0;
  assign alu_scode    = 2'b00;

  // ALU port mux; all zero outside the byte and multiply steps.
  always_comb begin
    alu_a        = 8'h00;
    alu_b        = 8'h00;
    alu_carry_in = 1'b0;
    alu_acode    = AC_ADD;
    case (state)
      S_LO: begin
        alu_a = a_q[7:0];
        case (op_q)
          OP_ADD: begin alu_b = b_q[7:0];  alu_acode = AC_ADD; end
          OP_SUB: begin alu_b = ~b_q[7:0]; alu_acode = AC_ADC; alu_carry_in = 1'b1; end
          default: begin alu_b = b_q[7:0]; alu_acode = logic_acode(op_q); end
        endcase
      end
      S_HI: begin
        alu_a = a_q[15:8];
        case (op_q)
          OP_ADD: begin alu_b = b_q[15:8];  alu_acode = AC_ADC; alu_carry_in = c_lo; end
          OP_SUB: begin alu_b = ~b_q[15:8]; alu_acode = AC_ADC; alu_carry_in = c_lo; end
          default: begin alu_b = b_q[15:8]; alu_acode = logic_acode(op_q); end
        endcase
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        alu_a = mul_p[15:8];
        alu_b = mul_p[0] ? b_q[7:0] : 8'h00;
      end
`endif
      default: ;
    endcase
  end

  // The ALU folds carry_in into alu_b within 8 bits, so 0xFF+1 wraps to 0
  // and loses the carry; restore it here.
  assign step_carry = (alu_acode == AC_ADC && alu_carry_in && alu_b == 8'hFF)
                      ? 1'b1 : alu_carry_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= 3'd0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      r_lo    <= 8'h00;
      z_lo    <= 1'b0;
      c_lo    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 16'h0000;
      zero    <= 1'b0;
      carry   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            if (!legal) begin
              // Result and flags keep their previous values.
              illegal <= 1'b1;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              illegal <= 1'b0;
              busy    <= 1'b1;
              state   <= (op == OP_MUL) ? S_MUL : S_LO;
            end
          end
        end
        S_LO: begin
          r_lo  <= alu_r;
          z_lo  <= alu_zero;
          c_lo  <= step_carry;
          state <= S_HI;
        end
        S_HI: begin
          result <= {alu_r, r_lo};
          zero   <= z_lo & alu_zero;
          carry  <= (op_q == OP_ADD || op_q == OP_SUB) ? step_carry : 1'b0;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= S_DONE;
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: begin
          if (mul_last) begin
            result <= mul_p_next;
            zero   <= (mul_p_next == 16'h0000);
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
